// File: rtl/domains_link_pkg.sv
// Shared types and helpers for the domains_link sender -> FIFO -> receiver link.
package domains_link_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DRAIN
  } sender_state_t;

  typedef enum logic {
    R_READY,
    R_IDLE
  } receiver_state_t;

  function automatic int level_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/domains_link_fifo.sv
// Synchronous show-ahead FIFO; push when full and pop when empty are ignored.
module domains_link_fifo
  import domains_link_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [DATA_W-1:0]                wdata,
  output logic [DATA_W-1:0]                rdata,
  output logic                             full,
  output logic                             empty,
  output logic [level_w(FIFO_DEPTH)-1:0]   level
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = level_w(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/domains_link.sv
// Burst sender -> FIFO -> rate-limited receiver link.
// Optional running checksum enabled by macro DOMAINS_LINK_CHECKSUM_EN.
//
// state   | meaning
// S_IDLE  | waiting for sender_trigger
// S_SEND  | pushing burst words, stalls while FIFO full
// S_DRAIN | all pushed, waiting for final receiver_rvalid
// R_READY | receiver pops whenever FIFO is non-empty
// R_IDLE  | receiver rest period after a pop
module domains_link
  import domains_link_pkg::*;
#(
  parameter int              DATA_W               = 8,
  parameter int              FIFO_DEPTH           = 4,
  parameter int              BURST_LEN            = 16,
  parameter int              RECEIVER_IDLE_CYCLES = 1,
  parameter logic [DATA_W-1:0] START_VALUE        = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sender_trigger,
  output logic                           sender_busy,
  output logic                           trigger_ignored,
  output logic [DATA_W-1:0]              receiver_rdata,
  output logic                           receiver_rvalid,
  output logic                           transfer_done,
  output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
  output logic [DATA_W-1:0]              receiver_csum
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam int IW = (RECEIVER_IDLE_CYCLES > 1) ? $clog2(RECEIVER_IDLE_CYCLES) : 1;

  sender_state_t   s_state, s_next;
  receiver_state_t r_state, r_next;

  logic [CW-1:0]     push_cnt;
  logic [DATA_W-1:0] next_word;
  logic [IW-1:0]     idle_cnt;
  logic              push;
  logic              pop;
  logic              accept;
  logic              done_next;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  domains_link_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (next_word),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    s_next    = s_state;
    push      = 1'b0;
    accept    = 1'b0;
    done_next = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (sender_trigger) begin
          accept = 1'b1;
          s_next = S_SEND;
        end
      end
      S_SEND: begin
        push = !fifo_full;
        if (push && (push_cnt == CW'(BURST_LEN - 1))) s_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Empty FIFO plus rvalid in drain can only be the final word.
        if (fifo_empty && receiver_rvalid) begin
          done_next = 1'b1;
          s_next    = S_IDLE;
        end
      end
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_state         <= S_IDLE;
      push_cnt        <= '0;
      next_word       <= START_VALUE;
      transfer_done   <= 1'b0;
      trigger_ignored <= 1'b0;
    end else begin
      s_state         <= s_next;
      transfer_done   <= done_next;
      trigger_ignored <= sender_trigger && (s_state != S_IDLE);
      if (accept) begin
        push_cnt  <= '0;
        next_word <= START_VALUE;
      end else if (push) begin
        push_cnt  <= push_cnt + CW'(1);
        next_word <= next_word + DATA_W'(1);
      end
    end
  end

  assign sender_busy = (s_state != S_IDLE);

  always_comb begin
    r_next = r_state;
    pop    = 1'b0;
    case (r_state)
      R_READY: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (RECEIVER_IDLE_CYCLES > 0) r_next = R_IDLE;
        end
      end
      R_IDLE: begin
        if (idle_cnt == '0) r_next = R_READY;
      end
      default: r_next = R_READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= R_READY;
      idle_cnt        <= '0;
      receiver_rdata  <= '0;
      receiver_rvalid <= 1'b0;
    end else begin
      r_state         <= r_next;
      receiver_rvalid <= pop;
      if (pop) begin
        receiver_rdata <= fifo_rdata;
        idle_cnt       <= IW'(RECEIVER_IDLE_CYCLES - 1);
      end else if ((r_state == R_IDLE) && (idle_cnt != '0)) begin
        idle_cnt <= idle_cnt - IW'(1);
      end
    end
  end

`ifdef DOMAINS_LINK_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      receiver_csum <= '0;
    end else if (accept) begin
      receiver_csum <= '0;
    end else if (pop) begin
      receiver_csum <= receiver_csum + fifo_rdata;
    end
  end
`else
  assign receiver_csum = '0;
`endif

endmodule

// File: tb/tb_domains_link.sv
// Directed bench for domains_link: three parameter sets checked against hand-computed timing and data.
module tb_domains_link;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst    [3];
  logic       trig   [3];
  logic       busy   [3];
  logic       ign    [3];
  logic       rvalid [3];
  logic       done   [3];
  logic [7:0] rdata  [3];
  logic [7:0] csum   [3];
  logic [2:0] level  [3];

  int total = 0;
  int bad   = 0;

`ifdef DOMAINS_LINK_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  domains_link #(.DATA_W(8), .FIFO_DEPTH(4), .BURST_LEN(16), .RECEIVER_IDLE_CYCLES(1),
                 .START_VALUE(8'h00)) dut_a (
    .clk(clk), .rst(rst[0]), .sender_trigger(trig[0]), .sender_busy(busy[0]),
    .trigger_ignored(ign[0]), .receiver_rdata(rdata[0]), .receiver_rvalid(rvalid[0]),
    .transfer_done(done[0]), .fifo_level(level[0]), .receiver_csum(csum[0]));

  domains_link #(.DATA_W(8), .FIFO_DEPTH(4), .BURST_LEN(16), .RECEIVER_IDLE_CYCLES(0),
                 .START_VALUE(8'h00)) dut_b (
    .clk(clk), .rst(rst[1]), .sender_trigger(trig[1]), .sender_busy(busy[1]),
    .trigger_ignored(ign[1]), .receiver_rdata(rdata[1]), .receiver_rvalid(rvalid[1]),
    .transfer_done(done[1]), .fifo_level(level[1]), .receiver_csum(csum[1]));

  domains_link #(.DATA_W(8), .FIFO_DEPTH(4), .BURST_LEN(4), .RECEIVER_IDLE_CYCLES(1),
                 .START_VALUE(8'hFE)) dut_c (
    .clk(clk), .rst(rst[2]), .sender_trigger(trig[2]), .sender_busy(busy[2]),
    .trigger_ignored(ign[2]), .receiver_rdata(rdata[2]), .receiver_rvalid(rvalid[2]),
    .transfer_done(done[2]), .fifo_level(level[2]), .receiver_csum(csum[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample i is taken at the falling edge after edge k+i, where edge k accepts the trigger.
  task automatic collect(input int d, input logic [7:0] start, input int n, input int gap,
                         input int lvl, input int done_at, input int hold, input int rep,
                         input logic [7:0] exp_csum);
    int         cnt      = 0;
    int         last     = -1;
    int         done_idx = -1;
    int         maxl     = 0;
    bit         prev;
    logic [7:0] ew;
    @(negedge clk);
    trig[d] = 1'b1;
    prev    = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("trigger_ignored", {31'b0, ign[d]}, {31'b0, (i > 0) && prev});
      if (i == 0) chk("busy_on_accept", {31'b0, busy[d]}, 32'd1);
      if (level[d] > maxl) maxl = level[d];
      if (rvalid[d]) begin
        ew = start + 8'(cnt);
        chk("rdata", {24'b0, rdata[d]}, {24'b0, ew});
        if (cnt == 0) chk("first_latency", i, 2);
        else          chk("rvalid_gap", i - last, gap);
        last = i;
        cnt++;
      end
      if (done[d]) begin
        done_idx = i;
        chk("busy_off_at_done", {31'b0, busy[d]}, 32'd0);
        chk("done_after_last_rvalid", i - last, 1);
        break;
      end
      prev    = (i < hold - 1) || (i == rep);
      trig[d] = prev;
    end
    trig[d] = 1'b0;
    chk("rvalid_count", cnt, n);
    chk("done_index", done_idx, done_at);
    chk("max_level", maxl, lvl);
    chk("csum_at_done", {24'b0, csum[d]}, {24'b0, exp_csum});
    repeat (3) begin
      @(negedge clk);
      chk("single_done", {31'b0, done[d]}, 32'd0);
      chk("busy_idle", {31'b0, busy[d]}, 32'd0);
    end
    chk("csum_hold", {24'b0, csum[d]}, {24'b0, exp_csum});
  endtask

  initial begin
    int cnt;
    for (int j = 0; j < 3; j++) begin
      rst[j]  = 1'b1;
      trig[j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'b0, busy[0]},   32'd0);
    chk("rst_ign",    {31'b0, ign[0]},    32'd0);
    chk("rst_rdata",  {24'b0, rdata[0]},  32'd0);
    chk("rst_rvalid", {31'b0, rvalid[0]}, 32'd0);
    chk("rst_done",   {31'b0, done[0]},   32'd0);
    chk("rst_level",  {29'b0, level[0]},  32'd0);
    chk("rst_csum",   {24'b0, csum[0]},   32'd0);
    for (int j = 0; j < 3; j++) rst[j] = 1'b0;

    // Default parameters: back-pressure, two-cycle spacing.
    collect(0, 8'h00, 16, 2, 4, 33, 1, -1, CSUM ? 8'h78 : 8'h00);
    // Receiver with no idle cycles.
    collect(1, 8'h00, 16, 1, 1, 18, 1, -1, CSUM ? 8'h78 : 8'h00);
    // Start value wraps through 0xFF.
    collect(2, 8'hFE, 4, 2, 2, 9, 1, -1, CSUM ? 8'hFE : 8'h00);
    // Trigger held three cycles then re-pulsed mid-burst, followed by a fresh burst.
    collect(0, 8'h00, 16, 2, 4, 33, 3, 10, CSUM ? 8'h78 : 8'h00);
    collect(0, 8'h00, 16, 2, 4, 33, 1, -1, CSUM ? 8'h78 : 8'h00);

    // Reset after five received words.
    @(negedge clk);
    trig[0] = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    cnt = (rvalid[0] === 1'b1) ? 1 : 0;
    for (int i = 0; i < 60 && cnt < 5; i++) begin
      @(negedge clk);
      if (rvalid[0] === 1'b1) cnt++;
    end
    chk("rst_reached_five", cnt, 5);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midrst_busy",   {31'b0, busy[0]},   32'd0);
    chk("midrst_rdata",  {24'b0, rdata[0]},  32'd0);
    chk("midrst_rvalid", {31'b0, rvalid[0]}, 32'd0);
    chk("midrst_done",   {31'b0, done[0]},   32'd0);
    chk("midrst_level",  {29'b0, level[0]},  32'd0);
    chk("midrst_csum",   {24'b0, csum[0]},   32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'b0, done[0], rvalid[0], busy[0]}, 32'd0);
      chk("post_rst_level", {29'b0, level[0]}, 32'd0);
    end
    collect(0, 8'h00, 16, 2, 4, 33, 1, -1, CSUM ? 8'h78 : 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
